// File: rtl/ee354_move_seq.sv
// Move/spawn sequencer for a 2048-style game board.
// Turns button presses into board move requests. It spawns a tile after each
// move that changed the board, then checks for a win or a loss.
// A press that arrives while a transaction is in flight is held in a
// one-deep pending slot. A hung move or spawn engine is caught by a watchdog.
module ee354_move_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  output logic        mv_start,
  output logic [1:0]  mv_dir,
  input  logic        mv_done,
  input  logic        mv_changed,
  output logic        sp_start,
  input  logic        sp_done,
  input  logic        tile_2048,
  input  logic        board_full,
  input  logic        can_merge,
  output logic        busy,
  output logic        q_win,
  output logic        q_lose,
  output logic        err,
  output logic [15:0] move_count
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StInit, StIdle, StMove, StSpawn, StCheck, StWin, StLose, StErr
  } state_e;

  state_e state_q, state_d;

  logic [3:0]      btn_prev_q;
  logic [3:0]      btn_now;
  logic [3:0]      btn_rise;
  logic            press_vld;
  logic [1:0]      press_dir;

  logic            pend_vld_q, pend_vld_d;
  logic [1:0]      pend_dir_q, pend_dir_d;
  logic [CntW-1:0] cnt_q;
  logic            mv_start_q, sp_start_q;
  logic [1:0]      mv_dir_q;
  logic [15:0]     count_q;
  logic            busy_q, win_q, lose_q, err_q;
  logic            busy_d, win_d, lose_d, err_d;

  logic            issue;
  logic [1:0]      issue_dir;
  logic            spawn_go;
  logic            move_inc;
  logic            mv_done_ok, sp_done_ok, timed_out;

  assign btn_now  = {up, down, left, right};
  assign btn_rise = btn_now & ~btn_prev_q;

  // Previous button levels; reset to 1 so a button held through reset is not a press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btn_prev_q <= 4'b1111;
    end else begin
      btn_prev_q <= btn_now;
    end
  end

  // Priority-encode simultaneous presses: up > down > left > right.
  always_comb begin
    press_vld = |btn_rise;
    press_dir = 2'b00;
    if (btn_rise[3])      press_dir = 2'b00;
    else if (btn_rise[2]) press_dir = 2'b01;
    else if (btn_rise[1]) press_dir = 2'b10;
    else if (btn_rise[0]) press_dir = 2'b11;
  end

  // Done pulses coincident with the start pulse are ignored.
  assign mv_done_ok = mv_done & ~mv_start_q;
  assign sp_done_ok = sp_done & ~sp_start_q;
  assign timed_out  = (cnt_q == CntLast);

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the handshake decisions that go with each transition.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_dir  = press_dir;
    spawn_go   = 1'b0;
    move_inc   = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;

    if (state_q == StIdle) begin
      pend_vld_d = 1'b0;
    end else if (press_vld && !pend_vld_q) begin
      pend_vld_d = 1'b1;
      pend_dir_d = press_dir;
    end

    unique case (state_q)
      StInit: begin
        state_d  = StSpawn;
        spawn_go = 1'b1;
      end
      StIdle: begin
        if (pend_vld_q) begin
          issue     = 1'b1;
          issue_dir = pend_dir_q;
        end else if (press_vld) begin
          issue = 1'b1;
        end
        if (issue) state_d = StMove;
      end
      StMove: begin
        if (mv_done_ok) begin
          if (mv_changed) begin
            state_d  = StSpawn;
            spawn_go = 1'b1;
            move_inc = 1'b1;
          end else begin
            state_d = StCheck;
          end
        end else if (timed_out) begin
          state_d = StErr;
        end
      end
      StSpawn: begin
        if (sp_done_ok)     state_d = StCheck;
        else if (timed_out) state_d = StErr;
      end
      StCheck: begin
        if (tile_2048)                     state_d = StWin;
        else if (board_full && !can_merge) state_d = StLose;
        else                               state_d = StIdle;
      end
      StWin, StLose, StErr: state_d = state_q;
      default: state_d = StInit;
    endcase
  end

  // Status outputs follow the state being entered, so they line up with the state itself.
  always_comb begin
    busy_d = (state_d == StInit) || (state_d == StMove) ||
             (state_d == StSpawn) || (state_d == StCheck);
    win_d  = (state_d == StWin);
    lose_d = (state_d == StLose);
    err_d  = (state_d == StErr);
  end

  // Datapath: start pulses, direction hold, watchdog, pending slot, move counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mv_start_q <= 1'b0;
      sp_start_q <= 1'b0;
      mv_dir_q   <= 2'b00;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_dir_q <= 2'b00;
      count_q    <= 16'h0000;
      busy_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mv_start_q <= issue;
      sp_start_q <= spawn_go;
      if (issue) mv_dir_q <= issue_dir;
      if (issue || spawn_go) begin
        cnt_q <= '0;
      end else if (state_q == StMove || state_q == StSpawn) begin
        cnt_q <= cnt_q + 1'b1;
      end
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      if (move_inc && count_q != 16'hFFFF) count_q <= count_q + 16'h0001;
      busy_q     <= busy_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      err_q      <= err_d;
    end
  end

  assign mv_start   = mv_start_q;
  assign sp_start   = sp_start_q;
  assign mv_dir     = mv_dir_q;
  assign move_count = count_q;
  assign busy       = busy_q;
  assign q_win      = win_q;
  assign q_lose     = lose_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ee354_move_seq.sv
// Directed bench for ee354_move_seq, built with an 8-cycle watchdog.
module tb_ee354_move_seq;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        up, down, left, right;
  logic        mv_start;
  logic [1:0]  mv_dir;
  logic        mv_done, mv_changed;
  logic        sp_start;
  logic        sp_done;
  logic        tile_2048, board_full, can_merge;
  logic        busy, q_win, q_lose, err;
  logic [15:0] move_count;

  int n_checks = 0;
  int n_fail   = 0;

  ee354_move_seq #(.TIMEOUT(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .mv_start   (mv_start),
    .mv_dir     (mv_dir),
    .mv_done    (mv_done),
    .mv_changed (mv_changed),
    .sp_start   (sp_start),
    .sp_done    (sp_done),
    .tile_2048  (tile_2048),
    .board_full (board_full),
    .can_merge  (can_merge),
    .busy       (busy),
    .q_win      (q_win),
    .q_lose     (q_lose),
    .err        (err),
    .move_count (move_count)
  );

  always #5 Clk = ~Clk;

  // Advance one cycle and settle just past the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reset, let the initial spawn finish with sp_done, and land in IDLE.
  task automatic reset_and_init();
    Reset = 1'b1;
    {up, down, left, right} = 4'b0000;
    {mv_done, mv_changed, sp_done} = 3'b000;
    {tile_2048, board_full, can_merge} = 3'b000;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    tick();
    sp_done = 1'b1;
    tick();
    sp_done = 1'b0;
    tick();
  endtask

  // Issue one move that leaves the board unchanged; returns after CHECK is left.
  task automatic move_nochange(input logic [3:0] btn);
    {up, down, left, right} = btn;
    tick();
    {up, down, left, right} = 4'b0000;
    tick();
    mv_done    = 1'b1;
    mv_changed = 1'b0;
    tick();
    mv_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    {up, down, left, right} = 4'b1000;
    {mv_done, mv_changed, sp_done} = 3'b000;
    {tile_2048, board_full, can_merge} = 3'b000;
    tick();
    tick();
    n_checks++;
    if ({mv_start, sp_start, busy, q_win, q_lose, err, mv_dir} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {mv_start, sp_start, busy, q_win, q_lose, err, mv_dir});
    end
    n_checks++;
    if (move_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", move_count);
    end
  endtask

  // Initial spawn with sp_done 3 cycles after sp_start; up is held through reset.
  task automatic test_init();
    int starts;
    Reset = 1'b0;
    tick();
    n_checks++;
    if (sp_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL init_sp_start: got sp_start=%b busy=%b want 1 1", sp_start, busy);
    end
    tick();
    n_checks++;
    if (sp_start !== 1'b0) begin
      n_fail++;
      $display("FAIL init_sp_pulse: got %b want 0", sp_start);
    end
    tick();
    tick();
    sp_done = 1'b1;
    tick();
    sp_done = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL init_check_busy: got %b want 1", busy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || move_count !== 16'd0) begin
      n_fail++;
      $display("FAIL init_idle: got busy=%b count=%0d want 0 0", busy, move_count);
    end
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mv_start === 1'b1) starts++;
    end
    n_checks++;
    if (starts !== 0) begin
      n_fail++;
      $display("FAIL held_button_press: got %0d mv_start want 0", starts);
    end
    up = 1'b0;
    tick();
  endtask

  // Up and right rise together: up wins, right is discarded.
  task automatic test_priority();
    int starts;
    up    = 1'b1;
    right = 1'b1;
    tick();
    n_checks++;
    if (mv_start !== 1'b1 || mv_dir !== 2'b00) begin
      n_fail++;
      $display("FAIL prio_start: got mv_start=%b dir=%b want 1 00", mv_start, mv_dir);
    end
    tick();
    n_checks++;
    if (mv_start !== 1'b0 || mv_dir !== 2'b00) begin
      n_fail++;
      $display("FAIL prio_pulse_hold: got mv_start=%b dir=%b want 0 00", mv_start, mv_dir);
    end
    mv_done    = 1'b1;
    mv_changed = 1'b1;
    tick();
    {mv_done, mv_changed} = 2'b00;
    n_checks++;
    if (sp_start !== 1'b1 || move_count !== 16'd1) begin
      n_fail++;
      $display("FAIL prio_spawn: got sp_start=%b count=%0d want 1 1", sp_start, move_count);
    end
    tick();
    sp_done = 1'b1;
    tick();
    sp_done = 1'b0;
    tick();
    {up, right} = 2'b00;
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      if (mv_start === 1'b1) starts++;
      tick();
    end
    n_checks++;
    if (starts !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_right_dropped: got starts=%0d busy=%b want 0 0", starts, busy);
    end
  endtask

  // Unchanged board: CHECK then IDLE, no spawn, count unchanged.
  task automatic test_no_change();
    left = 1'b1;
    tick();
    left = 1'b0;
    n_checks++;
    if (mv_start !== 1'b1 || mv_dir !== 2'b10) begin
      n_fail++;
      $display("FAIL nochg_start: got mv_start=%b dir=%b want 1 10", mv_start, mv_dir);
    end
    tick();
    mv_done    = 1'b1;
    mv_changed = 1'b0;
    tick();
    mv_done = 1'b0;
    n_checks++;
    if (sp_start !== 1'b0 || busy !== 1'b1 || move_count !== 16'd1) begin
      n_fail++;
      $display("FAIL nochg_check: got sp=%b busy=%b count=%0d want 0 1 1",
               sp_start, busy, move_count);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || move_count !== 16'd1) begin
      n_fail++;
      $display("FAIL nochg_idle: got busy=%b count=%0d want 0 1", busy, move_count);
    end
  endtask

  // Left then down during a move: left is kept, down dropped.
  task automatic test_pending();
    int starts;
    down = 1'b1;
    tick();
    down = 1'b0;
    n_checks++;
    if (mv_start !== 1'b1 || mv_dir !== 2'b01) begin
      n_fail++;
      $display("FAIL pend_first: got mv_start=%b dir=%b want 1 01", mv_start, mv_dir);
    end
    tick();
    left = 1'b1;
    tick();
    down = 1'b1;
    tick();
    mv_done    = 1'b1;
    mv_changed = 1'b0;
    tick();
    mv_done = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || mv_start !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_idle: got busy=%b mv_start=%b want 0 0", busy, mv_start);
    end
    tick();
    n_checks++;
    if (mv_start !== 1'b1 || mv_dir !== 2'b10) begin
      n_fail++;
      $display("FAIL pend_issue: got mv_start=%b dir=%b want 1 10", mv_start, mv_dir);
    end
    tick();
    mv_done = 1'b1;
    tick();
    mv_done = 1'b0;
    tick();
    {left, down} = 2'b00;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mv_start === 1'b1) starts++;
    end
    n_checks++;
    if (starts !== 0 || mv_dir !== 2'b10) begin
      n_fail++;
      $display("FAIL pend_down_dropped: got starts=%0d dir=%b want 0 10", starts, mv_dir);
    end
  endtask

  // Done pulses outside their state, or in the start cycle, are ignored.
  task automatic test_spurious();
    mv_done = 1'b1;
    sp_done = 1'b1;
    tick();
    {mv_done, sp_done} = 2'b00;
    tick();
    n_checks++;
    if (busy !== 1'b0 || sp_start !== 1'b0 || move_count !== 16'd1) begin
      n_fail++;
      $display("FAIL spur_idle: got busy=%b sp=%b count=%0d want 0 0 1",
               busy, sp_start, move_count);
    end
    right = 1'b1;
    tick();
    right      = 1'b0;
    mv_done    = 1'b1;
    mv_changed = 1'b1;
    tick();
    n_checks++;
    if (sp_start !== 1'b0 || busy !== 1'b1 || move_count !== 16'd1) begin
      n_fail++;
      $display("FAIL spur_start_cycle: got sp=%b busy=%b count=%0d want 0 1 1",
               sp_start, busy, move_count);
    end
    tick();
    {mv_done, mv_changed} = 2'b00;
    n_checks++;
    if (sp_start !== 1'b1 || move_count !== 16'd2) begin
      n_fail++;
      $display("FAIL spur_real_done: got sp=%b count=%0d want 1 2", sp_start, move_count);
    end
    tick();
    sp_done = 1'b1;
    tick();
    sp_done = 1'b0;
    tick();
  endtask

  // Full board: mergeable stays in play, unmergeable loses.
  task automatic test_lose();
    int starts;
    board_full = 1'b1;
    can_merge  = 1'b1;
    move_nochange(4'b1000);
    n_checks++;
    if (busy !== 1'b0 || q_lose !== 1'b0) begin
      n_fail++;
      $display("FAIL lose_mergeable: got busy=%b q_lose=%b want 0 0", busy, q_lose);
    end
    can_merge = 1'b0;
    move_nochange(4'b0100);
    n_checks++;
    if (q_lose !== 1'b1 || q_win !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lose_state: got q_lose=%b q_win=%b busy=%b want 1 0 0",
               q_lose, q_win, busy);
    end
    starts = 0;
    up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mv_start === 1'b1 || sp_start === 1'b1) starts++;
    end
    up = 1'b0;
    n_checks++;
    if (starts !== 0 || q_lose !== 1'b1) begin
      n_fail++;
      $display("FAIL lose_terminal: got starts=%0d q_lose=%b want 0 1", starts, q_lose);
    end
  endtask

  // 2048 on a full unmergeable board: win takes precedence.
  task automatic test_win();
    int starts;
    reset_and_init();
    tile_2048  = 1'b1;
    board_full = 1'b1;
    can_merge  = 1'b0;
    move_nochange(4'b0010);
    n_checks++;
    if (q_win !== 1'b1 || q_lose !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL win_state: got q_win=%b q_lose=%b busy=%b want 1 0 0", q_win, q_lose, busy);
    end
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      {up, down, left, right} = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      if (mv_start === 1'b1 || sp_start === 1'b1) starts++;
    end
    {up, down, left, right} = 4'b0000;
    n_checks++;
    if (starts !== 0) begin
      n_fail++;
      $display("FAIL win_terminal: got %0d starts want 0", starts);
    end
    {tile_2048, board_full} = 2'b00;
  endtask

  // Mid-move reset aborts; a stale mv_done afterwards has no effect.
  task automatic test_reset_abort();
    reset_and_init();
    down = 1'b1;
    tick();
    down = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mv_start !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: got busy=%b mv_start=%b want 0 0", busy, mv_start);
    end
    mv_done    = 1'b1;
    mv_changed = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (move_count !== 16'd0 || busy !== 1'b1 || sp_start !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stale_done: got count=%0d busy=%b sp=%b want 0 1 0",
               move_count, busy, sp_start);
    end
    {mv_done, mv_changed} = 2'b00;
    sp_done = 1'b1;
    tick();
    sp_done = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || move_count !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_recover: got busy=%b count=%0d want 0 0", busy, move_count);
    end
  endtask

  // No mv_done: err after 8 wait cycles, cleared by Reset which reruns INIT.
  task automatic test_timeout();
    int k;
    reset_and_init();
    up = 1'b1;
    tick();
    up = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (err === 1'b1) begin
        k = i;
        break;
      end
    end
    n_checks++;
    if (k !== 8) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d want 8 (0 means never)", k);
    end
    n_checks++;
    if (busy !== 1'b0 || q_win !== 1'b0 || q_lose !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_flags: got busy=%b win=%b lose=%b want 0 0 0", busy, q_win, q_lose);
    end
    Reset = 1'b1;
    tick();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_reset_err: got %b want 0", err);
    end
    Reset = 1'b0;
    tick();
    n_checks++;
    if (sp_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_reinit: got sp=%b busy=%b want 1 1", sp_start, busy);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_priority();
    test_no_change();
    test_pending();
    test_spurious();
    test_lose();
    test_win();
    test_reset_abort();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ee354_move_seq.md
EE354_MOVE_SEQ -- requirements
Module: ee354_move_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles to wait for mv_done or sp_done.
REQ-002 SHALL have port Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports up, down, left, right  input  1 each  synchronized button levels.
REQ-005 SHALL have port mv_start  output  1  one-cycle pulse requesting a board move.
REQ-006 SHALL have port mv_dir  output  2  move direction: 00 up, 01 down, 10 left, 11 right.
REQ-007 SHALL have ports mv_done  input  1  move complete pulse, and mv_changed  input  1  board altered, sampled with mv_done.
REQ-008 SHALL have port sp_start  output  1  one-cycle pulse requesting a new tile spawn.
REQ-009 SHALL have port sp_done  input  1  spawn complete pulse.
REQ-010 SHALL have ports tile_2048  input  1  board holds 2048, board_full  input  1  no empty cell, and can_merge  input  1  some adjacent pair is equal (all levels).
REQ-011 SHALL have ports busy, q_win, q_lose, err  output  1 each, and move_count  output  16.

Function
REQ-012 SHALL implement states INIT, IDLE, MOVE, SPAWN, CHECK, WIN, LOSE, ERR.
REQ-013 Press = rising edge of a button vs. its registered previous value.
REQ-014 Simultaneous presses in one cycle: priority up > down > left > right; others discarded.
REQ-015 INIT: one cycle; drive sp_start=1; next state SPAWN (initial tile).
REQ-016 IDLE: on press sampled at cycle N, mv_start=1 and mv_dir valid at cycle N+1 (registered); enter MOVE.
REQ-017 IDLE with a pending direction (REQ-022): issue it as in REQ-016 without needing a new press; clear pending.
REQ-018 MOVE: on mv_done&mv_changed -> SPAWN with sp_start pulsed the following cycle, move_count+1; on mv_done&!mv_changed -> CHECK, move_count unchanged.
REQ-019 SPAWN: on sp_done -> CHECK.
REQ-020 CHECK (one cycle): tile_2048 -> WIN; else board_full&!can_merge -> LOSE; else IDLE. tile_2048 has precedence when both hold.
REQ-021 WIN, LOSE, ERR are terminal until Reset; q_win / q_lose / err high only in respective state; no further mv_start/sp_start.
REQ-022 Press while not IDLE: store in one-deep pending register if empty; ignore if already occupied (first press kept).
REQ-023 mv_done/sp_done asserted outside MOVE/SPAWN respectively, or in the mv_start/sp_start cycle, SHALL be ignored.
REQ-024 Wait counter clears on entry to MOVE/SPAWN; when it reaches TIMEOUT without done -> ERR.
REQ-025 move_count SHALL saturate at 16'hFFFF.
REQ-026 busy SHALL be 1 in INIT, MOVE, SPAWN, CHECK; 0 otherwise.
REQ-027 mv_dir SHALL hold its value outside mv_start cycles.

Reset
REQ-028 On Reset: state INIT, all outputs 0, move_count 0, pending cleared, wait counter 0.
REQ-029 On Reset, registered previous button values SHALL be 1 so a button held through reset release is not a press.
REQ-030 Reset asserted mid-MOVE/SPAWN SHALL abort immediately; no done pulse afterwards affects state until INIT re-runs.

Verification
REQ-031 Reset release, sp_done 3 cycles after sp_start, flags 0 -> IDLE, busy=0, move_count=0.
REQ-032 IDLE, up and right rise same cycle -> one mv_start with mv_dir=00 next cycle; mv_done&mv_changed -> sp_start, move_count=1.
REQ-033 mv_done with mv_changed=0 -> no sp_start, CHECK then IDLE, move_count unchanged.
REQ-034 Presses left then down during MOVE -> after return to IDLE, one mv_start with mv_dir=10; down dropped.
REQ-035 CHECK with tile_2048=1, board_full=1, can_merge=0 -> q_win=1, q_lose=0; later presses produce no mv_start.
REQ-036 TIMEOUT=8, no mv_done after mv_start -> err=1 after 8 wait cycles; Reset -> err=0, state INIT.
